// File: rtl/id_pkg.sv
// Shared decode definitions: opcodes, funct codes, ALU operation codes and the control bundle.
// Used by the decode stage, its control decoder, and the ID/EX interface.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [5:0] {
    ALU_NONE = 6'd0,
    ALU_ADD  = 6'd1,
    ALU_SUB  = 6'd2,
    ALU_AND  = 6'd3,
    ALU_OR   = 6'd4,
    ALU_XOR  = 6'd5,
    ALU_NOR  = 6'd6,
    ALU_SLT  = 6'd7,
    ALU_BEQ  = 6'd8,
    ALU_BNE  = 6'd9
  } aluOp_t;

  // Field order is part of the EX contract: RegWrite is the MSB, ALUOp the low six bits.
  typedef struct packed {
    logic   RegWrite;
    logic   MemWrite;
    logic   MemRead;
    logic   MemtoReg;
    logic   RegDst;
    logic   ALUSrc;
    logic   Branch;
    logic   ZeroExtend;
    aluOp_t ALUOp;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = ctrl_t'(14'b0);

  // Instructions whose rt field is a source operand rather than a destination.
  function automatic logic readsRt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) ||
           (opcode == OP_BEQ) || (opcode == OP_BNE);
  endfunction

endpackage

// File: rtl/id_stage_pipelined_if.sv
// Registered ID-to-EX bundle. The decode stage drives it through master, EX consumes it through slave.
interface id_stage_pipelined_if
  import id_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              EX_Valid;
  logic [DATA_W-1:0] EX_ReadData1;
  logic [DATA_W-1:0] EX_ReadData2;
  logic [DATA_W-1:0] EX_Imm;
  logic [REG_AW-1:0] EX_Rs;
  logic [REG_AW-1:0] EX_Rt;
  logic [REG_AW-1:0] EX_Rd;
  ctrl_t             EX_Ctrl;

  modport master (
    output EX_Valid, EX_ReadData1, EX_ReadData2, EX_Imm,
           EX_Rs, EX_Rt, EX_Rd, EX_Ctrl
  );

  modport slave (
    input EX_Valid, EX_ReadData1, EX_ReadData2, EX_Imm,
          EX_Rs, EX_Rt, EX_Rd, EX_Ctrl
  );
endinterface

// File: rtl/id_ctrl_decode.sv
// Combinational instruction-to-control mapping. Anything unrecognised (including R-type with a
// non-zero shamt field) decodes to CTRL_NOP.
module id_ctrl_decode
  import id_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [4:0] shamt,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP_RTYPE: begin
        if (shamt == 5'd0) begin
          case (funct)
            FN_ADD:  ctrl.ALUOp = ALU_ADD;
            FN_SUB:  ctrl.ALUOp = ALU_SUB;
            FN_AND:  ctrl.ALUOp = ALU_AND;
            FN_OR:   ctrl.ALUOp = ALU_OR;
            FN_XOR:  ctrl.ALUOp = ALU_XOR;
            FN_NOR:  ctrl.ALUOp = ALU_NOR;
            FN_SLT:  ctrl.ALUOp = ALU_SLT;
            default: ctrl.ALUOp = ALU_NONE;
          endcase
        end
        if (ctrl.ALUOp != ALU_NONE) begin
          ctrl.RegWrite = 1'b1;
          ctrl.RegDst   = 1'b1;
        end
      end
      OP_LW: begin
        ctrl.RegWrite = 1'b1;
        ctrl.MemRead  = 1'b1;
        ctrl.MemtoReg = 1'b1;
        ctrl.ALUSrc   = 1'b1;
        ctrl.ALUOp    = ALU_ADD;
      end
      OP_SW: begin
        ctrl.MemWrite = 1'b1;
        ctrl.ALUSrc   = 1'b1;
        ctrl.ALUOp    = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.Branch = 1'b1;
        ctrl.ALUOp  = (opcode == OP_BEQ) ? ALU_BEQ : ALU_BNE;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.RegWrite = 1'b1;
        ctrl.ALUSrc   = 1'b1;
        // Logical immediates are zero-extended, arithmetic ones sign-extended.
        ctrl.ZeroExtend = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
        case (opcode)
          OP_ADDI: ctrl.ALUOp = ALU_ADD;
          OP_SLTI: ctrl.ALUOp = ALU_SLT;
          OP_ANDI: ctrl.ALUOp = ALU_AND;
          OP_ORI:  ctrl.ALUOp = ALU_OR;
          default: ctrl.ALUOp = ALU_XOR;
        endcase
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/id_stage_pipelined.sv
// Decode stage with register file, WB write-through bypass, flush and ID/EX register.
// Define ID_HAZARD_EN to build the load-use hazard unit; otherwise Stall is tied low.
module id_stage_pipelined
  import id_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int REG_AW = $clog2(NREGS)
)(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              IF_Valid,
  input  logic [31:0]       IF_Instruction,
  input  logic              Flush,
  input  logic              RegWrite_WB,
  input  logic [REG_AW-1:0] WriteRegister_WB,
  input  logic [DATA_W-1:0] WriteData_WB,
  output logic              Stall,
  id_stage_pipelined_if.master ex
);

  logic [5:0]        idOpcode;
  logic [REG_AW-1:0] idRs, idRt, idRd;
  logic [15:0]       idImm16;
  ctrl_t             idCtrl;
  logic [DATA_W-1:0] idImm, idReadData1, idReadData2;
  logic              wbEn;

  assign idOpcode = IF_Instruction[31:26];
  assign idRs     = IF_Instruction[21 +: REG_AW];
  assign idRt     = IF_Instruction[16 +: REG_AW];
  assign idRd     = IF_Instruction[11 +: REG_AW];
  assign idImm16  = IF_Instruction[15:0];

  id_ctrl_decode uDecode (
    .opcode (idOpcode),
    .shamt  (IF_Instruction[10:6]),
    .funct  (IF_Instruction[5:0]),
    .ctrl   (idCtrl)
  );

  assign idImm = idCtrl.ZeroExtend ? DATA_W'(idImm16) : DATA_W'($signed(idImm16));

  // Register file; entry 0 is never written and is masked on read regardless.
  logic [DATA_W-1:0] regFile [NREGS];

  assign wbEn = RegWrite_WB && (WriteRegister_WB != '0);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NREGS; i++) regFile[i] <= '0;
    end else if (wbEn) begin
      regFile[WriteRegister_WB] <= WriteData_WB;
    end
  end

  // WB writes in the same cycle are visible to ID without waiting for the array update.
  assign idReadData1 = (idRs == '0) ? '0 :
                       (wbEn && WriteRegister_WB == idRs) ? WriteData_WB : regFile[idRs];
  assign idReadData2 = (idRt == '0) ? '0 :
                       (wbEn && WriteRegister_WB == idRt) ? WriteData_WB : regFile[idRt];

  logic              exValidReg;
  logic [DATA_W-1:0] exReadData1Reg, exReadData2Reg, exImmReg;
  logic [REG_AW-1:0] exRsReg, exRtReg, exRdReg;
  ctrl_t             exCtrlReg;

`ifdef ID_HAZARD_EN
  logic loadUse;
  assign loadUse = exValidReg && exCtrlReg.MemRead && (exRtReg != '0) &&
                   ((exRtReg == idRs) || ((exRtReg == idRt) && readsRt(idOpcode)));
  assign Stall = !Rst && IF_Valid && loadUse;
`else
  assign Stall = 1'b0;
`endif

  // Reset, flush and stall all leave a fully zeroed bubble in ID/EX.
  always_ff @(posedge Clk) begin
    if (Rst || Flush || Stall) begin
      exValidReg     <= 1'b0;
      exCtrlReg      <= CTRL_NOP;
      exReadData1Reg <= '0;
      exReadData2Reg <= '0;
      exImmReg       <= '0;
      exRsReg        <= '0;
      exRtReg        <= '0;
      exRdReg        <= '0;
    end else begin
      exValidReg     <= IF_Valid;
      exCtrlReg      <= IF_Valid ? idCtrl : CTRL_NOP;
      exReadData1Reg <= idReadData1;
      exReadData2Reg <= idReadData2;
      exImmReg       <= idImm;
      exRsReg        <= idRs;
      exRtReg        <= idRt;
      exRdReg        <= idRd;
    end
  end

  assign ex.EX_Valid     = exValidReg;
  assign ex.EX_Ctrl      = exCtrlReg;
  assign ex.EX_ReadData1 = exReadData1Reg;
  assign ex.EX_ReadData2 = exReadData2Reg;
  assign ex.EX_Imm       = exImmReg;
  assign ex.EX_Rs        = exRsReg;
  assign ex.EX_Rt        = exRtReg;
  assign ex.EX_Rd        = exRdReg;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined: reset, bypass, immediates, load-use stall, flush.
// Expected stall behaviour follows whether ID_HAZARD_EN is defined for the build.
`timescale 1ns/1ps
module tb_id_stage_pipelined;

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;
`ifdef ID_HAZARD_EN
  localparam logic HZ = 1'b1;
`else
  localparam logic HZ = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Rst;
  logic              IF_Valid;
  logic [31:0]       IF_Instruction;
  logic              Flush;
  logic              RegWrite_WB;
  logic [REG_AW-1:0] WriteRegister_WB;
  logic [DATA_W-1:0] WriteData_WB;
  logic              Stall;

  id_stage_pipelined_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) exIf ();

  id_stage_pipelined #(.DATA_W(DATA_W), .NREGS(NREGS), .REG_AW(REG_AW)) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .IF_Valid         (IF_Valid),
    .IF_Instruction   (IF_Instruction),
    .Flush            (Flush),
    .RegWrite_WB      (RegWrite_WB),
    .WriteRegister_WB (WriteRegister_WB),
    .WriteData_WB     (WriteData_WB),
    .Stall            (Stall),
    .ex               (exIf)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [31:0] rType(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [13:0] ctrlBits(input logic rw, mw, mr, m2r, rd, src, br, ze, input logic [5:0] alu);
    return {rw, mw, mr, m2r, rd, src, br, ze, alu};
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic setWb(input logic en, input int r, input logic [31:0] d);
    RegWrite_WB      = en;
    WriteRegister_WB = 5'(r);
    WriteData_WB     = d;
  endtask

  task automatic issue(input logic v, input logic [31:0] ins);
    IF_Valid       = v;
    IF_Instruction = ins;
  endtask

  localparam logic [13:0] C_ADD  = 14'b1000_1000_000001;
  localparam logic [13:0] C_OR   = 14'b1000_1000_000100;
  localparam logic [13:0] C_ADDI = 14'b1000_0100_000001;
  localparam logic [13:0] C_ANDI = 14'b1000_0101_000011;
  localparam logic [13:0] C_LW   = 14'b1011_0100_000001;
  localparam logic [13:0] C_SW   = 14'b0100_0100_000001;
  localparam logic [13:0] C_BEQ  = 14'b0000_0010_001000;

  initial begin
    Rst = 1'b1;
    Flush = 1'b0;
    setWb(1'b0, 0, 32'h0);
    issue(1'b0, 32'h0);

    // Reset with random activity on every input.
    for (int i = 0; i < 2; i++) begin
      issue(1'($urandom), $urandom);
      Flush = 1'($urandom);
      setWb(1'($urandom), int'($urandom_range(0, 31)), $urandom);
      #1 checkEq("rst_stall", Stall, 1'b0);
      step();
      checkEq("rst_valid", exIf.EX_Valid, 1'b0);
      checkEq("rst_ctrl", exIf.EX_Ctrl, 14'b0);
    end
    Rst = 1'b0;
    Flush = 1'b0;
    setWb(1'b0, 0, 32'h0);

    issue(1'b1, rType(7, 31, 1, 6'h25));
    step();
    checkEq("or_valid", exIf.EX_Valid, 1'b1);
    checkEq("or_ctrl", exIf.EX_Ctrl, C_OR);
    checkEq("rst_rd1", exIf.EX_ReadData1, 32'h0);
    checkEq("rst_rd2", exIf.EX_ReadData2, 32'h0);
    checkEq("or_rd", exIf.EX_Rd, 5'd1);

    setWb(1'b1, 5, 32'hDEADBEEF);
    issue(1'b1, rType(5, 0, 1, 6'h20));
    step();
    checkEq("byp_rd1", exIf.EX_ReadData1, 32'hDEADBEEF);
    checkEq("byp_rd2", exIf.EX_ReadData2, 32'h0);
    checkEq("byp_rs", exIf.EX_Rs, 5'd5);
    checkEq("add_ctrl", exIf.EX_Ctrl, C_ADD);

    setWb(1'b1, 0, 32'h1234);
    issue(1'b1, rType(0, 5, 2, 6'h20));
    step();
    checkEq("r0_byp", exIf.EX_ReadData1, 32'h0);
    checkEq("file_r5", exIf.EX_ReadData2, 32'hDEADBEEF);

    setWb(1'b0, 0, 32'h0);
    issue(1'b1, rType(0, 0, 3, 6'h20));
    step();
    checkEq("r0_read", exIf.EX_ReadData1, 32'h0);

    setWb(1'b1, 6, 32'h11111111);
    issue(1'b0, rType(6, 6, 4, 6'h20));
    step();
    checkEq("inv_valid", exIf.EX_Valid, 1'b0);
    checkEq("inv_ctrl", exIf.EX_Ctrl, 14'b0);

    setWb(1'b1, 6, 32'h22222222);
    issue(1'b1, rType(6, 6, 7, 6'h20));
    step();
    checkEq("b2b_byp", exIf.EX_ReadData1, 32'h22222222);

    setWb(1'b0, 0, 32'h0);
    issue(1'b1, rType(6, 0, 7, 6'h20));
    step();
    checkEq("b2b_file", exIf.EX_ReadData1, 32'h22222222);

    issue(1'b1, iType(6'h08, 4, 8, 16'h8000));
    step();
    checkEq("addi_imm", exIf.EX_Imm, 32'hFFFF8000);
    checkEq("addi_ctrl", exIf.EX_Ctrl, C_ADDI);

    issue(1'b1, iType(6'h0C, 4, 8, 16'h8000));
    step();
    checkEq("andi_imm", exIf.EX_Imm, 32'h00008000);
    checkEq("andi_ctrl", exIf.EX_Ctrl, C_ANDI);
    checkEq("andi_zext", exIf.EX_Ctrl.ZeroExtend, 1'b1);

    issue(1'b1, iType(6'h04, 1, 2, 16'h0010));
    step();
    checkEq("beq_ctrl", exIf.EX_Ctrl, C_BEQ);
    checkEq("beq_imm", exIf.EX_Imm, 32'h10);

    issue(1'b1, iType(6'h3F, 1, 2, 16'h0));
    step();
    checkEq("unk_valid", exIf.EX_Valid, 1'b1);
    checkEq("unk_ctrl", exIf.EX_Ctrl, 14'b0);

    // lw r8,0(r2) then add r9,r8,r3
    issue(1'b1, iType(6'h23, 2, 8, 16'h0));
    #1 checkEq("lw_nostall", Stall, 1'b0);
    step();
    checkEq("lw_ctrl", exIf.EX_Ctrl, C_LW);
    checkEq("lw_rt", exIf.EX_Rt, 5'd8);
    issue(1'b1, rType(8, 3, 9, 6'h20));
    #1 checkEq("lu_stall", Stall, HZ);
    step();
    checkEq("lu_bubble", exIf.EX_Valid, !HZ);
    checkEq("lu_stall_done", Stall, 1'b0);
`ifdef ID_HAZARD_EN
    step();
`endif
    checkEq("lu_add_rs", exIf.EX_Rs, 5'd8);
    checkEq("lu_add_rd", exIf.EX_Rd, 5'd9);
    checkEq("lu_add_valid", exIf.EX_Valid, 1'b1);

    // lw r8 then addi r8,r4,1: rt is a destination, no stall.
    issue(1'b1, iType(6'h23, 2, 8, 16'h0));
    step();
    issue(1'b1, iType(6'h08, 4, 8, 16'h1));
    #1 checkEq("addi_nostall", Stall, 1'b0);
    step();
    checkEq("addi_loaded", exIf.EX_Ctrl, C_ADDI);

    // lw r0 then add r1,r0,r0: r0 never hazards.
    issue(1'b1, iType(6'h23, 2, 0, 16'h0));
    step();
    issue(1'b1, rType(0, 0, 1, 6'h20));
    #1 checkEq("r0_nostall", Stall, 1'b0);
    step();
    checkEq("r0_loaded", exIf.EX_Valid, 1'b1);

    // lw r8 then sw r8,0(r4): store reads rt.
    issue(1'b1, iType(6'h23, 2, 8, 16'h0));
    step();
    issue(1'b1, iType(6'h2B, 4, 8, 16'h0));
    #1 checkEq("sw_stall", Stall, HZ);
    step();
    checkEq("sw_bubble", exIf.EX_Valid, !HZ);
`ifdef ID_HAZARD_EN
    step();
`endif
    checkEq("sw_ctrl", exIf.EX_Ctrl, C_SW);

    // Flush together with a load-use stall.
    issue(1'b1, iType(6'h23, 2, 8, 16'h0));
    step();
    issue(1'b1, rType(8, 3, 9, 6'h20));
    Flush = 1'b1;
    #1 checkEq("fl_stall", Stall, HZ);
    step();
    Flush = 1'b0;
    checkEq("fl_valid", exIf.EX_Valid, 1'b0);
    checkEq("fl_ctrl", exIf.EX_Ctrl, 14'b0);
    checkEq("fl_rs", exIf.EX_Rs, 5'd0);
    issue(1'b1, rType(11, 12, 10, 6'h25));
    #1 checkEq("fl_nostall", Stall, 1'b0);
    step();
    checkEq("fl_next_valid", exIf.EX_Valid, 1'b1);
    checkEq("fl_next_rd", exIf.EX_Rd, 5'd10);

    // Reset in the middle of a load-use stall; the file is cleared too.
    issue(1'b1, iType(6'h23, 2, 8, 16'h0));
    step();
    issue(1'b1, rType(8, 5, 9, 6'h20));
    Rst = 1'b1;
    #1 checkEq("rs_stall", Stall, 1'b0);
    step();
    checkEq("rs_valid", exIf.EX_Valid, 1'b0);
    checkEq("rs_ctrl", exIf.EX_Ctrl, 14'b0);
    checkEq("rs_rs", exIf.EX_Rs, 5'd0);
    Rst = 1'b0;
    step();
    checkEq("post_rst_valid", exIf.EX_Valid, 1'b1);
    checkEq("post_rst_rs", exIf.EX_Rs, 5'd8);
    checkEq("post_rst_r5", exIf.EX_ReadData2, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_stage_pipelined.md
# id_stage_pipelined

Parametrised instruction-decode stage with its own ID/EX pipeline register, register file with WB-to-ID write-through bypass, load-use hazard detection and branch flush. Sits between the IF/ID register and the execute stage. It replaces the combinational decode path with a registered, stall- and flush-aware stage, and presents a single bundle of registered operands and control to EX.

## Interface
Parameters:
- DATA_W, 32, register and operand width
- NREGS, 32, register-file depth; power of two, at most 32; register 0 reads as zero
- REG_AW, $clog2(NREGS), register-address width

Ports:
- Clk  in  1  sole clock, rising edge
- Rst  in  1  synchronous, active-high reset
- IF_Valid  in  1  IF/ID holds a real instruction
- IF_Instruction  in  32  MIPS-format instruction word
- Flush  in  1  branch taken in EX; squash the instruction in ID
- RegWrite_WB  in  1  WB write enable
- WriteRegister_WB  in  REG_AW  WB destination register
- WriteData_WB  in  DATA_W  WB write data
- Stall  out  1  hold PC and IF/ID this cycle; combinational
- EX_Valid  out  1  ID/EX holds a real instruction
- EX_ReadData1, EX_ReadData2  out  DATA_W  registered operands (rs, rt)
- EX_Imm  out  DATA_W  sign- or zero-extended imm[15:0]
- EX_Rs, EX_Rt, EX_Rd  out  REG_AW  instruction fields [25:21], [20:16], [15:11]
- EX_Ctrl  out  14  {RegWrite, MemWrite, MemRead, MemtoReg, RegDst, ALUSrc, Branch, ZeroExtend, ALUOp[5:0]}, MSB first

## Operation
- The decoder produces control from IF_Instruction; ZeroExtend selects the extension mode for EX_Imm.
- Register file: NREGS×DATA_W, written on the rising edge when RegWrite_WB=1 and WriteRegister_WB≠0. Writes to register 0 are discarded.
- Bypass: if RegWrite_WB=1, WriteRegister_WB≠0 and it equals rs (or rt), the read returns WriteData_WB in the same cycle.
- Load-use hazard: Stall=1 when EX_Valid and EX_Ctrl.MemRead and EX_Rt≠0 and any of the following holds:
  - EX_Rt equals rs of the ID instruction, or
  - EX_Rt equals rt and the ID instruction reads rt (R-type, store, or branch).
- Stall has no effect unless IF_Valid=1.
- ID/EX update, evaluated in priority order each edge:
  1. Rst: all ID/EX fields are 0.
  2. Flush: bubble (EX_Valid=0, EX_Ctrl=0, other fields don't-care but driven to 0).
  3. Stall: bubble.
  4. Otherwise: load the decoded instruction, with EX_Valid=IF_Valid. When IF_Valid=0, EX_Ctrl is also forced to 0.
- Flush and Stall in the same cycle: the bubble is inserted and Stall remains asserted. The IF stage gives Flush priority over Stall when redirecting the PC.
- Invalid or unknown opcode: EX_Ctrl=0 and EX_Valid follows IF_Valid (acts as a NOP).

## Timing
- Latency: 1 cycle from IF_Instruction to EX_* outputs.
- Stall is combinational from IF_Instruction and the ID/EX state. It lasts exactly one cycle per load-use pair, because the bubble clears the MemRead condition.
- Reset, applied at a rising edge with Rst=1:
  - all EX_* outputs are 0;
  - all registers in the file are cleared to 0;
  - Stall is 0 while Rst=1.
- Reset mid-stall: the stall is abandoned and the ID/EX register is cleared. On the first cycle after Rst falls, the stage operates normally.
- Back-to-back WB writes to the same register: the last write wins. A bypass read reflects the current cycle's WB only.

## Configuration
- ID_HAZARD_EN defined: load-use detection and Stall are present as specified above.
- ID_HAZARD_EN undefined: Stall is tied to 0, and the ID/EX register loads every cycle unless Rst or Flush is asserted. Software must schedule load delay slots.
- The bypass and flush paths are present in both configurations.

## Structure
- Shared package id_pkg holds:
  - the opcode and funct localparams;
  - the ALUOp encodings;
  - the ctrl_t packed struct (14 bits) and its field order;
  - CTRL_NOP = 14'b0.
- One sub-module, id_ctrl_decode: a purely combinational mapping from instruction to ctrl_t, reusable by the future forwarding unit.
- The register file, bypass, hazard unit and ID/EX register are inline in id_stage_pipelined.

## Test plan
- Reset: hold Rst for 2 cycles with random inputs → EX_Valid=0, EX_Ctrl=0, Stall=0; a subsequent read of any register returns 0.
- Bypass: WB writes r5=0xDEADBEEF while ID decodes add r1,r5,r0 → next cycle EX_ReadData1=0xDEADBEEF. A WB write to r0 with value 0x1234 → later read of r0 = 0.
- Load-use stall: lw r8,0(r2) followed by add r9,r8,r3:
  - Stall=1 for exactly one cycle, and EX_Valid=0 on the following cycle;
  - the add then appears in EX with EX_Rs=8;
  - with ID_HAZARD_EN undefined, Stall stays 0.
- No false stall: lw r8 followed by addi r8,r4,1 (rt written, not read) → Stall=0. lw r0 followed by add r1,r0,r0 → Stall=0.
- Flush with stall: Flush=1 in the same cycle as a load-use stall → ID/EX is a bubble; the next cycle loads the new IF instruction with no residual stall.
- Immediate: addi with imm 0x8000 → EX_Imm=0xFFFF8000. andi with imm 0x8000 → EX_Imm=0x00008000, with EX_Ctrl.ZeroExtend=1.
